// File: rtl/fpadd_sequencer.sv
// fpadd_sequencer: round-robin two-port FP32 adder stage sequencer; define FPSEQ_ZERO_BYPASS_EN to short-circuit ±0 operands
module fpadd_sequencer #(
  parameter int NUM_STAGES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in0_valid,
  output logic                  in0_ready,
  input  logic [31:0]           in0_a,
  input  logic [31:0]           in0_b,
  input  logic                  in1_valid,
  output logic                  in1_ready,
  input  logic [31:0]           in1_a,
  input  logic [31:0]           in1_b,
  output logic [31:0]           fp_a,
  output logic [31:0]           fp_b,
  output logic [NUM_STAGES-1:0] fp_stage_en,
  input  logic [31:0]           fp_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_id,
  output logic [31:0]           out_result,
  output logic                  busy
);
  localparam int KW = $clog2(NUM_STAGES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_STAGES - 1);
  typedef enum logic [1:0] {IDLE, STAGE, RESP} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic last_grant, g0, g1, take;
  logic [31:0] a_sel, b_sel;
`ifdef FPSEQ_ZERO_BYPASS_EN
  logic za, zb;
  logic [31:0] byp_res;
`endif
  always_comb begin
    g0 = in0_valid & (~in1_valid | last_grant);
    g1 = in1_valid & ~g0;
    in0_ready = ~reset & (state == IDLE) & g0;
    in1_ready = ~reset & (state == IDLE) & g1;
    take = in0_ready | in1_ready;
    a_sel = g1 ? in1_a : in0_a;
    b_sel = g1 ? in1_b : in0_b;
`ifdef FPSEQ_ZERO_BYPASS_EN
    za = a_sel[30:0] == 31'b0;
    zb = b_sel[30:0] == 31'b0;
    byp_res = (za & zb) ? {a_sel[31] & b_sel[31], 31'b0} : za ? b_sel : a_sel;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      last_grant <= 1'b1;
      fp_a <= '0;
      fp_b <= '0;
      fp_stage_en <= '0;
      out_valid <= 1'b0;
      out_id <= 1'b0;
      out_result <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          fp_a <= a_sel;
          fp_b <= b_sel;
          out_id <= g1;
          last_grant <= g1;
          busy <= 1'b1;
          k <= '0;
`ifdef FPSEQ_ZERO_BYPASS_EN
          if (za | zb) begin
            state <= RESP;
            out_valid <= 1'b1;
            out_result <= byp_res;
          end else begin
            state <= STAGE;
            fp_stage_en <= NUM_STAGES'(1);
          end
`else
          state <= STAGE;
          fp_stage_en <= NUM_STAGES'(1);
`endif
        end
        STAGE: if (k == K_LAST) begin
          state <= RESP;
          fp_stage_en <= '0;
          out_result <= fp_result;
          out_valid <= 1'b1;
        end else begin
          k <= k + 1'b1;
          fp_stage_en <= fp_stage_en << 1;
        end
        RESP: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpadd_sequencer.sv
// tb_fpadd_sequencer: scoreboard bench against a cycle-level reference model of the sequencer
module tb_fpadd_sequencer;
  localparam int N = 5;
  logic clk = 1'b0, reset = 1'b1;
  logic in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0;
  logic in0_ready, in1_ready, out_valid, out_id, busy;
  logic [31:0] fp_a, fp_b, fp_result, out_result;
  logic [N-1:0] fp_stage_en;
  int checks = 0, fails = 0, cyc = 0, n_acc = 0;
  bit inflight = 0, last = 1, rst_prev = 0, byp = 0;
  int t_acc = 0, lat = 0;
  logic [31:0] exp_a, exp_b;
  logic [32:0] q[$];

  fpadd_sequencer #(.NUM_STAGES(N)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b),
    .fp_a(fp_a), .fp_b(fp_b), .fp_stage_en(fp_stage_en), .fp_result(fp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_result(out_result), .busy(busy)
  );

  function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : (a + b) ^ 32'h0F0F0F0F;
  endfunction

  function automatic bit is_zero(input logic [31:0] v);
    return v[30:0] == 31'b0;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v = $urandom;
    int r = $urandom_range(0, 3);
    return r == 0 ? (v & 32'h80000000) : r == 1 ? (v & 32'h807FFFFF) : v;
  endfunction

  assign fp_result = fp_stage_en[N-1] ? add_model(fp_a, fp_b) : 32'hDEADBEEF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit e0, e1, wid;
    int d;
    logic [31:0] res, a, b;
    if (reset) begin
      chk("ready_in_reset", {30'b0, in0_ready, in1_ready}, 32'd0);
      q.delete();
      inflight = 0;
      last = 1;
      rst_prev = 1;
    end else begin
      if (rst_prev) begin
        chk("rst_fp_a", fp_a, 32'd0);
        chk("rst_fp_b", fp_b, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_id", {31'b0, out_id}, 32'd0);
      end
      rst_prev = 0;
      e0 = !inflight && in0_valid && (!in1_valid || last);
      e1 = !inflight && in1_valid && (!in0_valid || !last);
      chk("ready", {30'b0, in0_ready, in1_ready}, {30'b0, e0, e1});
      d = cyc - t_acc;
      chk("busy", {31'b0, busy}, {31'b0, inflight});
      chk("stage_en", 32'(fp_stage_en),
          (inflight && !byp && d >= 1 && d <= N) ? 32'd1 << (d - 1) : 32'd0);
      chk("out_valid", {31'b0, out_valid}, {31'b0, inflight && d >= lat});
      if (inflight) begin
        chk("fp_a", fp_a, exp_a);
        chk("fp_b", fp_b, exp_b);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_response", 32'd1, 32'd0);
        else begin
          chk("out_id", {31'b0, out_id}, {31'b0, q[0][32]});
          chk("out_result", out_result, q[0][31:0]);
        end
      end
      if (inflight && d >= lat && out_ready) begin
        void'(q.pop_front());
        inflight = 0;
      end
      if (e0 || e1) begin
        wid = e1;
        a = wid ? in1_a : in0_a;
        b = wid ? in1_b : in0_b;
`ifdef FPSEQ_ZERO_BYPASS_EN
        byp = is_zero(a) || is_zero(b);
`else
        byp = 0;
`endif
        res = !byp ? add_model(a, b) : (is_zero(a) && is_zero(b)) ? {a[31] & b[31], 31'b0}
            : is_zero(a) ? b : a;
        q.push_back({wid, res});
        lat = byp ? 1 : N + 1;
        inflight = 1;
        t_acc = cyc;
        exp_a = a;
        exp_b = b;
        last = wid;
        n_acc++;
      end
    end
  end

  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b);
    int n = n_acc;
    if (id) begin in1_valid = 1; in1_a = a; in1_b = b; end
    else begin in0_valid = 1; in0_a = a; in0_b = b; end
    for (int i = 0; i < 100 && n_acc == n; i++) begin @(posedge clk); #1; end
    chk("accept_timeout", 32'(n_acc == n), 32'd0);
    in0_valid = 0;
    in1_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && inflight; i++) begin @(posedge clk); #1; end
    chk("idle_timeout", {31'b0, inflight}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    send(0, 32'h3F800000, 32'h40000000);
    wait_idle();
    in0_valid = 1;
    in1_valid = 1;
    repeat (60) begin
      in0_a = rnd_op(); in0_b = rnd_op(); in1_a = rnd_op(); in1_b = rnd_op();
      @(posedge clk); #1;
    end
    in0_valid = 0;
    in1_valid = 0;
    wait_idle();
    out_ready = 0;
    send(0, 32'h40A00000, 32'hC0400000);
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    chk("bp_valid_timeout", {31'b0, out_valid}, 32'd1);
    in0_valid = 1;
    in1_valid = 1;
    repeat (10) begin @(posedge clk); #1; end
    out_ready = 1;
    repeat (10) begin @(posedge clk); #1; end
    in0_valid = 0;
    in1_valid = 0;
    wait_idle();
    send(1, 32'h41200000, 32'h3F000000);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    send(0, 32'h3F800000, 32'h40000000);
    wait_idle();
    send(1, 32'h80000000, 32'h3F800000);
    wait_idle();
    send(0, 32'h80000000, 32'h00000000);
    wait_idle();
    repeat (400) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      in0_a = rnd_op(); in0_b = rnd_op(); in1_a = rnd_op(); in1_b = rnd_op();
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    in0_valid = 0;
    in1_valid = 0;
    out_ready = 1;
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
